// File: rtl/led_target_generator.sv
// Reaction-game target generator: lights one pseudo-random LED per round, reports hit/miss.
// Optional macro SPEEDUP_EN shrinks the lit window every 4 completed rounds.
module led_target_generator #(
   parameter int unsigned NUM_LEDS   = 18,
   parameter int unsigned ON_CYCLES  = 25000000,
   parameter int unsigned GAP_CYCLES = 5000000,
   parameter int unsigned NUM_ROUNDS = 15,
   parameter logic [17:0] LFSR_SEED  = 18'h2B5A1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [NUM_LEDS-1:0] switches,
   output logic [NUM_LEDS-1:0] leds,
   output logic [4:0]          target_idx,
   output logic [4:0]          round_num,
   output logic                hit_pulse,
   output logic                miss_pulse,
   output logic                busy,
   output logic                game_over
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

   state_t              r_state;
   logic [17:0]         r_lfsr;
   logic [TW-1:0]       r_timer;
   logic [4:0]          r_prev_idx;
   logic [NUM_LEDS-1:0] r_sw_meta;
   logic [NUM_LEDS-1:0] r_sw_s;
   logic [NUM_LEDS-1:0] r_sw_d;

   logic [NUM_LEDS-1:0] w_rise;
   logic                w_target_rise;
   logic [5:0]          w_v;
   logic [4:0]          w_fold;
   logic [4:0]          w_pick;
   logic [TW-1:0]       w_on_last;

   assign w_rise        = r_sw_s & ~r_sw_d;
   // leds is the one-hot target while in SHOW, so it doubles as the rise select mask
   assign w_target_rise = |(w_rise & leds);

   always_comb begin
      w_v    = {1'b0, r_lfsr[4:0]};
      w_fold = (w_v < 6'(NUM_LEDS)) ? r_lfsr[4:0] : 5'(w_v - 6'(NUM_LEDS));
      w_pick = w_fold;
      if (w_fold == r_prev_idx)
         w_pick = (r_prev_idx == 5'(NUM_LEDS - 1)) ? '0 : r_prev_idx + 5'd1;
   end

`ifdef SPEEDUP_EN
   logic [TW-1:0] w_window;
   logic [31:0]   w_shift;

   always_comb begin
      w_shift   = ON_CYCLES >> round_num[4:2];
      w_window  = (w_shift == '0) ? TW'(1) : TW'(w_shift);
      w_on_last = w_window - TW'(1);
   end
`else
   assign w_on_last = TW'(ON_CYCLES - 1);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_lfsr     <= LFSR_SEED;
         r_timer    <= '0;
         r_prev_idx <= '0;
         r_sw_meta  <= '0;
         r_sw_s     <= '0;
         r_sw_d     <= '0;
         leds       <= '0;
         target_idx <= '0;
         round_num  <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         busy       <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         r_lfsr     <= {r_lfsr[16:0], r_lfsr[17] ^ r_lfsr[10]};
         r_sw_meta  <= switches;
         r_sw_s     <= r_sw_meta;
         r_sw_d     <= r_sw_s;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;

         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  round_num  <= '0;
                  target_idx <= w_pick;
                  leds       <= NUM_LEDS'(1) << w_pick;
                  r_timer    <= '0;
                  busy       <= 1'b1;
                  game_over  <= 1'b0;
                  r_state    <= SHOW;
               end
            end

            SHOW: begin
               if (w_target_rise || (r_timer == w_on_last)) begin
                  // a hit on the final cycle of the window takes priority over the timeout
                  hit_pulse  <= w_target_rise;
                  miss_pulse <= ~w_target_rise;
                  leds       <= '0;
                  r_timer    <= '0;
                  round_num  <= round_num + 5'd1;
                  r_prev_idx <= target_idx;
                  r_state    <= GAP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            GAP: begin
               if (r_timer == TW'(GAP_CYCLES - 1)) begin
                  if (round_num == 5'(NUM_ROUNDS)) begin
                     busy      <= 1'b0;
                     game_over <= 1'b1;
                     r_state   <= DONE;
                  end else begin
                     target_idx <= w_pick;
                     leds       <= NUM_LEDS'(1) << w_pick;
                     r_timer    <= '0;
                     r_state    <= SHOW;
                  end
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_target_generator.sv
// Randomised self-checking bench for led_target_generator against a round-level reference model.
module tb_led_target_generator;

   localparam int unsigned N   = 18;
   localparam int unsigned ON  = 8;
   localparam int unsigned GP  = 4;
   localparam int unsigned NR  = 3;
   localparam logic [17:0] SEED = 18'h2B5A1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] switches;
   logic [N-1:0] leds;
   logic [4:0]   target_idx;
   logic [4:0]   round_num;
   logic         hit_pulse;
   logic         miss_pulse;
   logic         busy;
   logic         game_over;

   int checks = 0;
   int errors = 0;
   int edge_cnt;
   int unsigned m_prev;

   led_target_generator #(
      .NUM_LEDS  (N),
      .ON_CYCLES (ON),
      .GAP_CYCLES(GP),
      .NUM_ROUNDS(NR),
      .LFSR_SEED (SEED)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .switches  (switches),
      .leds      (leds),
      .target_idx(target_idx),
      .round_num (round_num),
      .hit_pulse (hit_pulse),
      .miss_pulse(miss_pulse),
      .busy      (busy),
      .game_over (game_over)
   );

   always #5 clk = ~clk;

   // Number of clock edges since reset release; the LFSR has stepped this many times.
   always @(posedge clk or posedge reset) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] lfsr_at(input int n);
      logic [17:0] l;
      l = SEED;
      for (int i = 0; i < n; i++) l = {l[16:0], l[17] ^ l[10]};
      return l;
   endfunction

   function automatic int unsigned pick(input int n, input int unsigned prev);
      logic [17:0] l;
      int unsigned v, idx;
      l   = lfsr_at(n);
      v   = int'(l[4:0]);
      idx = (v < N) ? v : v - N;
      if (idx == prev) idx = (prev == N - 1) ? 0 : prev + 1;
      return idx;
   endfunction

   function automatic int win(input int r);
      int w;
`ifdef SPEEDUP_EN
      w = ON >> (r / 4);
      if (w < 1) w = 1;
`else
      w = ON;
`endif
      return w;
   endfunction

   // modes: 0 miss, 1 hit at random offset, 2 switches held from before SHOW,
   //        3 non-target toggles plus a stray start, 4 hit on the last window cycle
   task automatic play_game(input int m0, input int m1, input int m2);
      int          modes[3];
      int unsigned exp_idx, last_dut, nt;
      int          a, exp_k, got_k;
      logic [N-1:0] exp_leds;
      modes[0] = m0; modes[1] = m1; modes[2] = m2;
      last_dut = 0;
      switches = (modes[0] == 2) ? '1 : '0;
      repeat (3) @(negedge clk);
      start   = 1'b1;
      exp_idx = pick(edge_cnt, m_prev);
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < int'(NR); r++) begin
         exp_leds = '0;
         exp_leds[exp_idx] = 1'b1;
         chk("target_idx", 32'(target_idx), exp_idx);
         chk("leds_show", 32'(leds), 32'(exp_leds));
         chk("busy_show", 32'(busy), 1);
         chk("round_show", 32'(round_num), r);
         if (r > 0) chk("target_repeat", 32'(target_idx == 5'(last_dut)), 0);
         last_dut = int'(target_idx);
         m_prev   = exp_idx;
         nt       = (exp_idx + 1) % N;
         a = (modes[r] == 1) ? int'($urandom_range(0, 5)) : (modes[r] == 4) ? win(r) - 3 : -1;
         exp_k = (a >= 0) ? a + 3 : win(r);
         got_k = -1;
         for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (hit_pulse || miss_pulse) begin
               got_k = k;
               break;
            end
            if (k == a) switches[exp_idx] = 1'b1;
            if (modes[r] == 3) begin
               case (k)
                  1: begin switches[nt] = 1'b1; start = 1'b1; end
                  2: start = 1'b0;
                  3: switches[nt] = 1'b0;
                  4: switches[nt] = 1'b1;
                  default: ;
               endcase
            end
         end
         start = 1'b0;
         chk("pulse_cycle", got_k, exp_k);
         chk("hit_pulse", 32'(hit_pulse), 32'(a >= 0));
         chk("miss_pulse", 32'(miss_pulse), 32'(a < 0));
         chk("leds_gap", 32'(leds), 0);
         chk("busy_gap", 32'(busy), 1);
         chk("round_gap", 32'(round_num), r + 1);
         switches = (r + 1 < int'(NR) && modes[r + 1] == 2) ? '1 : '0;
         @(negedge clk);
         chk("pulse_width", 32'({hit_pulse, miss_pulse}), 0);
         repeat (2) @(negedge clk);
         if (r + 1 < int'(NR)) exp_idx = pick(edge_cnt, m_prev);
         @(negedge clk);
      end
      chk("game_over", 32'(game_over), 1);
      chk("busy_done", 32'(busy), 0);
      chk("round_done", 32'(round_num), NR);
      chk("leds_done", 32'(leds), 0);
      switches = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      switches = '0;
      m_prev   = 0;
      repeat (2) @(negedge clk);
      chk("rst_leds", 32'(leds), 0);
      chk("rst_outs", 32'({target_idx, round_num, hit_pulse, miss_pulse, busy, game_over}), 0);
      reset = 1'b0;

      play_game(0, 0, 0);
      play_game(1, 2, 3);
      play_game(4, 1, 0);

      // reset in the middle of the second round, checked before any clock edge
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_leds", 32'(leds), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_over", 32'(game_over), 0);
      chk("mid_rst_round", 32'(round_num), 0);
      chk("mid_rst_tgt", 32'(target_idx), 0);
      @(negedge clk);
      reset  = 1'b0;
      m_prev = 0;

      for (int g = 0; g < 5; g++)
         play_game(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
